fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the datapath.
- Holds the program counter and issues reads to a synchronous instruction memory.
- Buffers returned words in a 2-entry queue and hands them to the datapath over a valid/ready handshake.
- Supports PC redirect (branch/jump from the datapath) and halt.

Parameters:
ADDR_W, 8, instruction address width (PC width)
INSTR_W, 8, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
imem_en  output  1  read request to instruction memory this cycle
imem_addr  output  ADDR_W  read address, valid when imem_en=1
imem_rdata  input  INSTR_W  read data, valid exactly one cycle after the imem_en cycle
instr  output  INSTR_W  instruction at head of buffer
instr_pc  output  ADDR_W  address of instr
instr_valid  output  1  buffer head is valid
instr_ready  input  1  datapath accepts head this cycle
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address
halt  input  1  suppress new requests while high

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC; queue empty; inflight=0; squash=0; instr_valid=0; imem_en=0; instr=0; instr_pc=0.
- Handshake: transfer occurs when instr_valid && instr_ready. instr and instr_pc stay stable while valid && !ready.
- Request rule (combinational): imem_en = !rst && !redirect && !halt && (count + inflight - pop < 2).
  - count is queue occupancy (0..2).
  - inflight is 1 if a request was issued last cycle.
  - pop is the handshake transfer this cycle.
  - imem_addr = pc.
  - When imem_en=1, pc <= pc+1, modulo 2^ADDR_W: 0xFF wraps to 0x00, with no flag.
- Response: in the cycle after a request, imem_rdata is pushed with its PC (pc latched at issue) unless squash=1. The push is visible as instr_valid in the following cycle. No combinational bypass.
- Latency and throughput:
  - First request is issued in the cycle rst is low.
  - instr_valid rises 2 cycles after that request cycle.
  - With instr_ready held high, one instruction per cycle is sustained.
- Backpressure: the credit rule guarantees a push never meets a full queue. A push to a full queue is a design error and an assertion must fire.
- Simultaneous push and pop: both are legal in the same cycle; occupancy is unchanged.
- Redirect, in the cycle redirect=1:
  - No request is issued.
  - Queue is cleared at the edge, and a pop in that cycle is still counted as accepted.
  - pc <= redirect_pc.
  - If inflight=1, squash <= 1 so the returning word next cycle is dropped. squash clears after one cycle.
  - The first request from redirect_pc is issued the next cycle. instr_valid for redirect_pc appears 3 cycles after the redirect cycle.
- Redirect on consecutive cycles: the last one wins. Each redirect re-clears the queue.
- Halt: no new requests while high. In-flight and queued words are still delivered. Fetch resumes at the current pc on the cycle halt drops.
- Redirect while halted: pc updates and the queue flushes; no request is issued until halt=0.
- Reset mid-operation: rst overrides redirect and halt. All state returns to reset values at the edge. A response arriving the cycle after reset is dropped, because inflight=0 after reset.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INSTR_W, RESET_PC defaults, and the instruction word typedef shared with datapath/decode.
- Sub-module fetch_buffer: 2-entry synchronous FIFO of {pc, instr} with push, pop, flush, count, head outputs. Flush has priority over push.

Test Plan:
- Reset/start-up: memory holds mem[i]=0xA0+i, rst high 3 cycles, ready=1 -> imem_addr 0,1,2,... from the first cycle after reset. instr 0xA0 @pc0 valid 2 cycles later, then 0xA1, 0xA2 on consecutive cycles.
- Backpressure: ready=0 for 5 cycles from the first valid -> exactly 2 words queued, imem_en low while full, instr=0xA0 stable. On ready=1 the sequence 0xA0, 0xA1, 0xA2 continues with no loss or duplicate.
- Redirect with in-flight: redirect=1, redirect_pc=0x10 while the request for pc=5 is in flight -> 0xA5 never appears. Next accepted is instr_pc=0x10, valid 3 cycles after the redirect cycle.
- Wrap: redirect_pc=0xFE, ready=1 -> accepted pcs 0xFE, 0xFF, 0x00, 0x01.
- Halt: halt=1 for 4 cycles mid-stream -> already-requested words are delivered and imem_en stays 0. After halt drops, fetch continues at the next pc without a gap or repeat.
- Simultaneous events: redirect and handshake in the same cycle -> the head is consumed once and the queue is emptied. Reset asserted mid-stream -> instr_valid=0 next cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and word types used by fetch, decode and the datapath.
package cpu_pkg;

    localparam int CPU_ADDR_W   = 8;
    localparam int CPU_INSTR_W  = 8;
    localparam int CPU_RESET_PC = 0;

    typedef logic [CPU_INSTR_W-1:0] instr_t;
    typedef logic [CPU_ADDR_W-1:0]  addr_t;

    // Fetched word tagged with the address it came from
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between the instruction memory and the datapath.
// Flush wins over push; popping an empty buffer is ignored.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int INSTR_W = CPU_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [ADDR_W-1:0]  pc_mem    [2];
    logic [INSTR_W-1:0] instr_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_pop;

    assign do_pop     = pop && (count != 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // Fetch credits make this unreachable; a hit means the issue logic is broken
            assert (!(push && count == 2'd2));
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency memory reads and
// queues returned words for the datapath, with redirect and halt support.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int RESET_PC = CPU_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] issue_pc;
    logic              inflight;
    logic              squash;
    logic [1:0]        count;
    logic              pop;
    logic              push;
    logic [2:0]        credit;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;

    // Slots committed after this cycle: never lets a returning word meet a full buffer
    assign credit    = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign imem_en   = !rst && !redirect && !halt && (credit < 3'd2);
    assign imem_addr = pc;
    assign push      = inflight && !squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= ADDR_W'(RESET_PC);
            issue_pc <= ADDR_W'(RESET_PC);
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            inflight <= imem_en;
            squash   <= redirect && inflight;
            if (imem_en)
                issue_pc <= pc;
            if (redirect)
                pc <= redirect_pc;
            else if (imem_en)
                pc <= pc + ADDR_W'(1);
        end
    end

    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (issue_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle checks on the request side plus a
// scoreboard of expected {pc, instr} for every accepted handshake.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    addr_t       imem_addr;
    instr_t      imem_rdata = '0;
    instr_t      instr;
    addr_t       instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    addr_t       redirect_pc;
    logic        halt;

    int tests = 0;
    int fails = 0;
    fetch_entry_t exp_q[$];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    function automatic instr_t memv(input addr_t a);
        return instr_t'(8'hA0 + a);
    endfunction

    // Synchronous instruction memory: mem[i] = 0xA0 + i
    always @(posedge clk)
        if (imem_en) imem_rdata <= memv(imem_addr);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input addr_t a);
        fetch_entry_t e;
        e.pc    = a;
        e.instr = memv(a);
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst && instr_valid && instr_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL sb_extra observed pc=%h instr=%h expected=none", instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                assert ({instr_pc, instr} === {e.pc, e.instr}) else begin
                    fails++;
                    $error("FAIL sb_data observed pc=%h instr=%h expected pc=%h instr=%h",
                           instr_pc, instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 16'(instr_valid), 16'd0);
        check("rst_en",    16'(imem_en),     16'd0);
        check("rst_instr", 16'(instr),       16'd0);
        check("rst_pc",    16'(instr_pc),    16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Start-up: C0..C5, one request per cycle, first valid two cycles later
        rst = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(addr_t'(i));
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next();
            @(negedge clk);
            check("start_en",    16'(imem_en),     16'd1);
            check("start_addr",  16'(imem_addr),   16'(c));
            check("start_valid", 16'(instr_valid), 16'(c >= 2));
        end

        // C6: reset mid-stream
        next(); rst = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        check("mrst_en", 16'(imem_en), 16'd0);

        // C7..C17: restart at RESET_PC, then 5 cycles of backpressure from first valid
        for (int c = 7; c <= 17; c++) begin
            next();
            if (c == 7) begin
                rst = 1'b0;
                check("sb_drain_a", 16'(exp_q.size()), 16'd0);
                for (int i = 0; i < 5; i++) expect_pc(addr_t'(i));
            end
            if (c == 14) instr_ready = 1'b1;
            @(negedge clk);
            check("bp_en", 16'(imem_en), 16'(c <= 8 || c >= 14));
            if (c <= 8)  check("bp_addr", 16'(imem_addr), 16'(c - 7));
            if (c >= 14) check("bp_addr", 16'(imem_addr), 16'(c - 12));
            check("bp_valid", 16'(instr_valid), 16'(c >= 9));
            if (c >= 9 && c <= 14) check("bp_hold", 16'({instr_pc, instr}), 16'h00A0);
        end

        // C18: redirect to 0x10 while pc5 is in flight, head pc4 consumed same cycle
        next(); redirect = 1'b1; redirect_pc = 8'h10;
        @(negedge clk);
        check("rd_en",   16'(imem_en),  16'd0);
        check("rd_head", 16'(instr_pc), 16'd4);

        // C19..C30: new stream with halt over C23..C26
        for (int c = 19; c <= 30; c++) begin
            next();
            if (c == 19) begin
                redirect = 1'b0;
                check("sb_drain_b", 16'(exp_q.size()), 16'd0);
                for (int i = 16; i <= 22; i++) expect_pc(addr_t'(i));
            end
            halt = (c >= 23 && c <= 26);
            @(negedge clk);
            check("h_en", 16'(imem_en), 16'(c <= 22 || c >= 27));
            if (c <= 22) check("h_addr", 16'(imem_addr), 16'(8'h10 + c - 19));
            if (c >= 27) check("h_addr", 16'(imem_addr), 16'(8'h14 + c - 27));
            check("h_valid", 16'(instr_valid), 16'((c >= 21 && c <= 24) || c >= 29));
        end

        // C31: redirect to 0xFE
        next(); redirect = 1'b1; redirect_pc = 8'hFE;
        @(negedge clk);
        check("rw_en",   16'(imem_en),  16'd0);
        check("rw_head", 16'(instr_pc), 16'h16);

        // C32..C37: address wrap 0xFE, 0xFF, 0x00, 0x01
        for (int c = 32; c <= 37; c++) begin
            next();
            if (c == 32) begin
                redirect = 1'b0;
                check("sb_drain_c", 16'(exp_q.size()), 16'd0);
                expect_pc(8'hFE); expect_pc(8'hFF); expect_pc(8'h00); expect_pc(8'h01);
            end
            @(negedge clk);
            check("w_en",    16'(imem_en),     16'd1);
            check("w_addr",  16'(imem_addr),   16'(addr_t'(8'hFE + c - 32)));
            check("w_valid", 16'(instr_valid), 16'(c >= 34));
        end

        next(); instr_ready = 1'b0; halt = 1'b1;
        @(negedge clk);
        check("sb_drain_d", 16'(exp_q.size()), 16'd0);
        repeat (3) next();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
